// File: rtl/ula_pkg.sv
// Shared opcode map, FSM state type and dispatch helper for the multi-cycle ALU.
package ula_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_MUL   = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_MOD   = 5'd4;
  localparam logic [4:0] OP_AND   = 5'd5;
  localparam logic [4:0] OP_OR    = 5'd6;
  localparam logic [4:0] OP_XOR   = 5'd7;
  localparam logic [4:0] OP_NOT   = 5'd8;
  localparam logic [4:0] OP_LAND  = 5'd9;
  localparam logic [4:0] OP_LOR   = 5'd10;
  localparam logic [4:0] OP_SLL   = 5'd11;
  localparam logic [4:0] OP_SRL   = 5'd12;
  localparam logic [4:0] OP_PASSA = 5'd13;
  localparam logic [4:0] OP_PASSB = 5'd14;
  localparam logic [4:0] OP_EQ    = 5'd15;
  localparam logic [4:0] OP_NE    = 5'd16;
  localparam logic [4:0] OP_LT    = 5'd17;
  localparam logic [4:0] OP_LE    = 5'd18;
  localparam logic [4:0] OP_GT    = 5'd19;
  localparam logic [4:0] OP_GE    = 5'd20;
  localparam logic [4:0] OP_JF    = 5'd21;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} estado_t;

  function automatic logic is_multiciclo(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/divisor_restaurador.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles after load.
// pronto marks the cycle in which quociente/resto already carry the final step.
module divisor_restaurador #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             pronto
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] quo, rem, dvs;
  logic [CW-1:0]    cnt;
  logic             running;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] quo_n, rem_n;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_n = diff[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = shifted[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end
  end

  assign quociente = quo_n;
  assign resto     = rem_n;
  assign pronto    = running && (cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      quo     <= dividend;
      rem     <= '0;
      dvs     <= divisor;
      cnt     <= CW'(WIDTH - 1);
      running <= 1'b1;
    end else if (running) begin
      quo <= quo_n;
      rem <= rem_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0) running <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle ops finish in one cycle, MUL uses an inline
// shift-add loop and DIV/MOD use the restoring divider, both WIDTH cycles long.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       aluOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic             flagBranch,
  output logic             divZero
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(WIDTH);

  estado_t          state, state_next, entry;
  logic [4:0]       op_r;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_step;
  logic [SHW-1:0]   cnt;
  logic             accept, div_op, b_zero, div_load;
  logic [WIDTH-1:0] quo, rem;
  logic             pronto;

  function automatic logic [WIDTH-1:0] bit1(input logic c);
    return {{(WIDTH-1){1'b0}}, c};
  endfunction

  // DIV/MOD only reach this path with a zero divisor.
  function automatic logic [WIDTH-1:0] alu_simples(input logic [4:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_DIV:   r = '1;
      OP_MOD:   r = a;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT:   r = ~a;
      OP_LAND:  r = bit1((a != '0) && (b != '0));
      OP_LOR:   r = bit1((a != '0) || (b != '0));
      OP_SLL:   r = (b < LIM) ? (a << b[SHW-1:0]) : '0;
      OP_SRL:   r = (b < LIM) ? (a >> b[SHW-1:0]) : '0;
      OP_PASSA: r = a;
      OP_PASSB: r = b;
      OP_EQ:    r = bit1(a == b);
      OP_NE:    r = bit1(a != b);
      OP_LT:    r = bit1(a < b);
      OP_LE:    r = bit1(a <= b);
      OP_GT:    r = bit1(a > b);
      OP_GE:    r = bit1(a >= b);
      OP_JF:    r = b;
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign div_op   = (aluOp == OP_DIV) || (aluOp == OP_MOD);
  assign b_zero   = (B == '0);
  assign div_load = accept && div_op && !b_zero;
  assign acc_step = acc + (mplier[0] ? mcand : '0);

  divisor_restaurador #(.WIDTH(WIDTH)) u_div (
    .clock    (clock),
    .reset    (reset),
    .load     (div_load),
    .dividend (A),
    .divisor  (B),
    .quociente(quo),
    .resto    (rem),
    .pronto   (pronto)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    if (aluOp == OP_MUL)         entry = MUL;
    else if (div_op && !b_zero)  entry = DIV;
    else                         entry = DONE;
    case (state)
      IDLE: if (start) state_next = entry;
      MUL: begin
        busy = 1'b1;
        if (cnt == '0) state_next = DONE;
      end
      DIV: begin
        busy = 1'b1;
        if (pronto) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? entry : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_r       <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      resultado  <= '0;
      flagBranch <= 1'b0;
      divZero    <= 1'b0;
    end else if (accept) begin
      op_r   <= aluOp;
      mcand  <= A;
      mplier <= B;
      acc    <= '0;
      cnt    <= SHW'(WIDTH - 1);
      // Anything not entering MUL/DIV completes on this edge.
      if (!is_multiciclo(aluOp) || (div_op && b_zero)) begin
        resultado <= alu_simples(aluOp, A, B);
        divZero   <= div_op && b_zero;
        if (aluOp == OP_JF) flagBranch <= (A == WIDTH'(1));
      end
    end else if (state == MUL) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == '0) begin
        resultado <= acc_step;
        divZero   <= 1'b0;
      end
    end else if ((state == DIV) && pronto) begin
      resultado <= (op_r == OP_MOD) ? rem : quo;
      divZero   <= 1'b0;
    end
  end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Parametrised, multi-cycle successor to the CPU's combinational ALU.
- Same 5-bit opcode map (0..21), generalised to WIDTH-bit operands.
- MUL, DIV and MOD are iterative, so the block no longer needs a wide combinational multiplier or divider.
- Sits in the execute stage. The control unit stalls on `busy` and consumes `resultado` on `done`.

Parameters:
- WIDTH, 32, operand/result width in bits (even, ≥ 8).
- SHW, $clog2(WIDTH), shift-amount bits taken from B for ops 11/12.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; accepted only when busy=0.
- aluOp  in  5  operation code, sampled on accepted start.
- A  in  WIDTH  first operand, sampled on accepted start.
- B  in  WIDTH  second operand, sampled on accepted start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; resultado valid in that cycle.
- resultado  out  WIDTH  registered result; holds until the next done.
- flagBranch  out  1  branch flag; written only by op 21.
- divZero  out  1  set with done when DIV/MOD had B=0; else 0 at done.

Behaviour:
- Reset (sync, high):
  - state=IDLE.
  - busy, done, flagBranch, divZero, resultado all 0.
  - Counter and operand registers cleared.
  - Reset mid-operation aborts it and produces no done.
- States: IDLE, MUL, DIV, DONE.
- busy is 1 in MUL and DIV, 0 in IDLE and DONE.
- start with busy=0 (IDLE or DONE) latches aluOp, A and B. This allows back-to-back issue.
- start while busy=1 is ignored. No queueing.
- Single-cycle ops (all except 2, 3, 4):
  - IDLE → DONE.
  - done=1 on the cycle after start. Latency 1.
- MUL (op 2):
  - IDLE → MUL. Radix-2 shift-add over WIDTH cycles, counter WIDTH-1 down to 0.
  - Then → DONE. Latency WIDTH+1.
  - resultado = low WIDTH bits of A*B (unsigned).
- DIV/MOD (ops 3, 4), B≠0:
  - IDLE → DIV. Restoring division over WIDTH cycles.
  - Then → DONE. Latency WIDTH+1.
  - DIV gives the quotient; MOD gives the remainder (unsigned).
- DIV/MOD, B=0:
  - IDLE → DONE. Latency 1, divZero=1.
  - DIV result is all ones; MOD result is A.
- DONE lasts one cycle: done=1. Next state is IDLE, or the new op's state if start is accepted.
- Arithmetic and relational rules:
  - Ops 0/1 wrap modulo 2^WIDTH.
  - All relationals (15–20) are unsigned; result is 1 or 0, zero-extended.
  - Ops 9/10 are logical AND/OR, giving 1 or 0.
  - Op 8 is ~A. Op 13 returns A. Op 14 returns B.
- Shifts (11, 12):
  - Logical shift by B[SHW-1:0] when B < WIDTH.
  - If B ≥ WIDTH, result is 0.
- Op 21:
  - flagBranch ← (A==1) at done.
  - resultado ← B.
- flagBranch holds its value across all other ops.
- Opcodes 22–31: resultado=0, latency 1, flagBranch unchanged.
- divZero is updated only at done. Cleared at done for any op other than a zero-divisor DIV/MOD.
- resultado changes only on the done cycle.

Decomposition:
- Package ula_pkg:
  - Opcode localparams OP_ADD=0 … OP_JF=21.
  - State enum {IDLE, MUL, DIV, DONE}.
  - Helper function is_multiciclo(op).
- Sub-module divisor_restaurador:
  - Parameter WIDTH.
  - Ports: clock, reset, load, dividend, divisor → quociente, resto, pronto.
  - Iterative, WIDTH cycles.
  - The top FSM drives its load and waits on pronto.
- The multiplier stays inline in the top module (accumulator plus shift register).

Test Plan:
- WIDTH=32, start, op0, A=0xFFFFFFFF, B=2 → next cycle done=1, resultado=0x00000001, busy never high.
- op2, A=1234, B=5678 → busy high 32 cycles, done at cycle 33, resultado=7006652. A second start during busy is ignored.
- op3, A=100, B=7 → done at cycle 33, resultado=14. Then back-to-back op4 issued in the DONE cycle → resultado=2.
- op3, A=9, B=0 → done next cycle, resultado=0xFFFFFFFF, divZero=1. Following op0 → divZero=0.
- op21, A=1, B=0x40 → flagBranch=1, resultado=0x40. Then op0 leaves flagBranch=1. op21 with A=3 → flagBranch=0.
- Assert reset mid-MUL at cycle 10 → next cycle all outputs 0, no done. op11 with B=40 → resultado=0. op25 → resultado=0.
